// File: rtl/mem_subsystem_if.sv
`default_nettype none
// ============================================================================
//  Module      : mem_subsystem_if
//  Description : CPU-side bus of the memory subsystem. Request signals,
//                read data and status outputs grouped for modport use.
//  Revision    : 1.0  initial release
// ============================================================================
interface mem_subsystem_if;
  logic [31:0] address;
  logic [31:0] mem_out;
  logic        mem_read;
  logic        mem_write;
  logic [31:0] mem_in;
  logic [31:0] out_port;
  logic [3:0]  wb_count;
  logic        wb_empty;

  // CPU side: issues requests, consumes read data and status
  modport master (
    output address, mem_out, mem_read, mem_write,
    input  mem_in, out_port, wb_count, wb_empty
  );

  // Memory side: serves requests, produces read data and status
  modport slave (
    input  address, mem_out, mem_read, mem_write,
    output mem_in, out_port, wb_count, wb_empty
  );
endinterface
`default_nettype wire

// File: rtl/mem_subsystem.sv
`default_nettype none
// ============================================================================
//  Module      : mem_subsystem
//  Description : Single-port data RAM behind a posted write buffer, plus a
//                small memory-mapped register window (output port, cycle
//                counter). Reads forward from the youngest matching buffer
//                entry so posted writes are never observed stale.
//  Revision    : 1.0  initial release
// ============================================================================
module mem_subsystem #(
  parameter int          WB_DEPTH  = 4,
  parameter int          RAM_WORDS = 256,
  parameter logic [31:0] IO_BASE   = 32'h0000_FF00
) (
  input  wire logic     clk,
  input  wire logic     rst,
  mem_subsystem_if.slave bus
);

  localparam int RAM_AW = $clog2(RAM_WORDS);
  localparam int WB_AW  = $clog2(WB_DEPTH);

  // Storage
  logic [31:0]       r_ram       [RAM_WORDS];
  logic [RAM_AW-1:0] r_fifo_idx  [WB_DEPTH];
  logic [31:0]       r_fifo_data [WB_DEPTH];

  // Buffer bookkeeping and registers
  logic [WB_AW-1:0]  r_head;
  logic [WB_AW-1:0]  r_tail;
  logic [WB_AW:0]    r_count;
  logic [31:0]       r_out_port;
  logic [31:0]       r_cycle;

  // Decode and control
  logic              w_is_io;
  logic [1:0]        w_io_off;
  logic [RAM_AW-1:0] w_ram_idx;
  logic              w_ram_wr;
  logic              w_empty;
  logic              w_full;
  logic              w_enq;
  logic              w_drain;
  logic              w_fwd_hit;
  logic [31:0]       w_fwd_data;
  logic [31:0]       w_io_rdata;
  logic [31:0]       w_ram_rdata;
  logic              w_unused_addr;

  // Byte-lane bits carry no meaning for word accesses
  assign w_unused_addr = ^bus.address[1:0];

  assign w_is_io   = (bus.address[31:4] == IO_BASE[31:4]);
  assign w_io_off  = bus.address[3:2];
  assign w_ram_idx = bus.address[RAM_AW+1:2];
  assign w_ram_wr  = bus.mem_write && !w_is_io;

  assign w_empty   = (r_count == '0);
  assign w_full    = (r_count == (WB_AW+1)'(WB_DEPTH));

  // A full buffer with a new RAM write is drained regardless of the read
  // port, so the enqueue below always has a free slot.
  assign w_enq     = w_ram_wr;
  assign w_drain   = !w_empty && (!bus.mem_read || (w_full && w_ram_wr));

  // Forwarding search: walk oldest to youngest so the youngest match wins.
  // The head entry still counts while it drains this cycle.
  always_comb begin
    logic [WB_AW-1:0] pos;
    pos        = '0;
    w_fwd_hit  = 1'b0;
    w_fwd_data = '0;
    for (int k = 0; k < WB_DEPTH; k++) begin
      pos = r_head + WB_AW'(k);
      if (((WB_AW+1)'(k) < r_count) && (r_fifo_idx[pos] == w_ram_idx)) begin
        w_fwd_hit  = 1'b1;
        w_fwd_data = r_fifo_data[pos];
      end
    end
  end

  // Register window read mux
  always_comb begin
    w_io_rdata = '0;
    case (w_io_off)
      2'd0:    w_io_rdata = r_out_port;
      2'd1:    w_io_rdata = r_cycle;
      default: w_io_rdata = '0;
    endcase
  end

  assign w_ram_rdata = w_fwd_hit ? w_fwd_data : r_ram[w_ram_idx];

  assign bus.mem_in   = !bus.mem_read ? 32'h0 :
                        (w_is_io ? w_io_rdata : w_ram_rdata);
  assign bus.out_port = r_out_port;
  assign bus.wb_count = 4'(r_count);
  assign bus.wb_empty = w_empty;

  // Buffer payload and RAM write port; reset blocks both but clears neither
  always_ff @(posedge clk) begin
    if (!rst && w_enq) begin
      r_fifo_idx[r_tail]  <= w_ram_idx;
      r_fifo_data[r_tail] <= bus.mem_out;
    end
    if (!rst && w_drain) begin
      r_ram[r_fifo_idx[r_head]] <= r_fifo_data[r_head];
    end
  end

  // Pointers, occupancy, output port and free-running cycle counter
  always_ff @(posedge clk) begin
    if (rst) begin
      r_head     <= '0;
      r_tail     <= '0;
      r_count    <= '0;
      r_out_port <= '0;
      r_cycle    <= '0;
    end else begin
      r_cycle <= r_cycle + 32'd1;
      if (w_enq) begin
        r_tail <= r_tail + 1'b1;
      end
      if (w_drain) begin
        r_head <= r_head + 1'b1;
      end
      if (w_enq && !w_drain) begin
        r_count <= r_count + 1'b1;
      end else if (!w_enq && w_drain) begin
        r_count <= r_count - 1'b1;
      end
      if (bus.mem_write && w_is_io && (w_io_off == 2'd0)) begin
        r_out_port <= bus.mem_out;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_mem_subsystem.sv
`default_nettype none
// ============================================================================
//  Module      : tb_mem_subsystem
//  Description : Directed bench for mem_subsystem: forwarding, forced drain,
//                register window, same-cycle read/write and reset behaviour.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_mem_subsystem;

  logic clk;
  logic rst;
  int   n_assert;
  int   n_fail;
  logic [31:0] tb_cyc;
  logic [31:0] v1;

  mem_subsystem_if bus ();

  mem_subsystem #(
    .WB_DEPTH  (4),
    .RAM_WORDS (256),
    .IO_BASE   (32'h0000_FF00)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference cycle counter: zero on a reset edge, +1 on every other edge
  always @(posedge clk) begin
    if (rst) tb_cyc <= 32'd0;
    else     tb_cyc <= tb_cyc + 32'd1;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Drive one cycle's request shortly after the falling edge
  task automatic apply(input logic rd, input logic wr, input logic [31:0] a, input logic [31:0] d);
    bus.mem_read  = rd;
    bus.mem_write = wr;
    bus.address   = a;
    bus.mem_out   = d;
    #1;
  endtask

  task automatic cyc();
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      apply(1'b0, 1'b0, 32'h0, 32'h0);
      cyc();
    end
  endtask

  initial begin
    n_assert = 0;
    n_fail   = 0;
    rst      = 1'b1;
    apply(1'b0, 1'b0, 32'h0, 32'h0);
    repeat (2) cyc();
    rst = 1'b0;

    // Reset state
    chk("rst_wb_count", 32'(bus.wb_count), 32'd0);
    chk("rst_wb_empty", 32'(bus.wb_empty), 32'd1);
    chk("rst_out_port", bus.out_port, 32'h0);
    apply(1'b1, 1'b0, 32'hFF04, 32'h0);
    chk("rst_counter", bus.mem_in, 32'h0);
    apply(1'b0, 1'b0, 32'hFF04, 32'h0);
    chk("read_low_zero", bus.mem_in, 32'h0);
    cyc();

    // Posted write then forwarded read
    apply(1'b0, 1'b1, 32'h10, 32'h1234_5678);
    cyc();
    apply(1'b1, 1'b0, 32'h10, 32'h0);
    chk("fwd_read_0x10", bus.mem_in, 32'h1234_5678);
    chk("fwd_wb_count", 32'(bus.wb_count), 32'd1);
    cyc();
    chk("no_drain_on_read", 32'(bus.wb_count), 32'd1);
    idle(2);
    chk("drain_empty_1", 32'(bus.wb_empty), 32'd1);
    apply(1'b1, 1'b0, 32'h10, 32'h0);
    chk("ram_read_0x10", bus.mem_in, 32'h1234_5678);
    cyc();

    // Fill the buffer while reading, then force a drain
    apply(1'b1, 1'b1, 32'h0, 32'hA000_0000); cyc();
    apply(1'b1, 1'b1, 32'h4, 32'hA000_0001); cyc();
    apply(1'b1, 1'b1, 32'h8, 32'hA000_0002); cyc();
    apply(1'b1, 1'b1, 32'hC, 32'hA000_0003); cyc();
    chk("full_wb_count", 32'(bus.wb_count), 32'd4);
    apply(1'b1, 1'b1, 32'h10, 32'hA000_0004); cyc();
    chk("forced_wb_count", 32'(bus.wb_count), 32'd4);
    apply(1'b1, 1'b0, 32'h0, 32'h0);
    chk("rb_0x00", bus.mem_in, 32'hA000_0000);
    cyc();
    apply(1'b1, 1'b0, 32'h4, 32'h0);
    chk("rb_0x04", bus.mem_in, 32'hA000_0001);
    cyc();
    apply(1'b1, 1'b0, 32'h8, 32'h0);
    chk("rb_0x08", bus.mem_in, 32'hA000_0002);
    cyc();
    apply(1'b1, 1'b0, 32'hC, 32'h0);
    chk("rb_0x0C", bus.mem_in, 32'hA000_0003);
    cyc();
    apply(1'b1, 1'b0, 32'h10, 32'h0);
    chk("rb_0x10", bus.mem_in, 32'hA000_0004);
    cyc();
    // Aliased index: 0x410 maps onto word 4 of a 256-word RAM
    apply(1'b1, 1'b0, 32'h410, 32'h0);
    chk("alias_0x410", bus.mem_in, 32'hA000_0004);
    cyc();
    idle(4);
    chk("drain_empty_2", 32'(bus.wb_empty), 32'd1);
    apply(1'b1, 1'b0, 32'hC, 32'h0);
    chk("ram_0x0C", bus.mem_in, 32'hA000_0003);
    cyc();

    // Two writes to one word: youngest entry wins
    apply(1'b1, 1'b1, 32'h20, 32'hA); cyc();
    apply(1'b1, 1'b1, 32'h20, 32'hB);
    chk("same_cycle_old_0x20", bus.mem_in, 32'hA);
    cyc();
    apply(1'b1, 1'b0, 32'h20, 32'h0);
    chk("youngest_0x20", bus.mem_in, 32'hB);
    chk("two_entries", 32'(bus.wb_count), 32'd2);
    cyc();
    idle(4);
    chk("drain_empty_3", 32'(bus.wb_empty), 32'd1);
    apply(1'b1, 1'b0, 32'h20, 32'h0);
    chk("ram_0x20", bus.mem_in, 32'hB);
    cyc();

    // Register window
    apply(1'b1, 1'b1, 32'h30, 32'h3333); cyc();
    apply(1'b1, 1'b1, 32'hFF00, 32'hDEAD_BEEF);
    chk("io_old_out_port", bus.mem_in, 32'h0);
    cyc();
    chk("out_port", bus.out_port, 32'hDEAD_BEEF);
    chk("io_wb_count", 32'(bus.wb_count), 32'd1);
    apply(1'b1, 1'b0, 32'hFF00, 32'h0);
    chk("io_read_port", bus.mem_in, 32'hDEAD_BEEF);
    cyc();
    apply(1'b1, 1'b0, 32'hFF04, 32'h0);
    v1 = bus.mem_in;
    chk("counter_a", v1, tb_cyc);
    cyc();
    apply(1'b1, 1'b0, 32'hFF04, 32'h0);
    chk("counter_b", bus.mem_in, tb_cyc);
    chk("counter_step", bus.mem_in - v1, 32'd1);
    cyc();
    apply(1'b1, 1'b1, 32'hFF0C, 32'h5555_5555); cyc();
    apply(1'b1, 1'b0, 32'hFF0C, 32'h0);
    chk("io_0x0C_zero", bus.mem_in, 32'h0);
    chk("io_wr_no_enq", 32'(bus.wb_count), 32'd1);
    cyc();
    apply(1'b1, 1'b0, 32'hFF08, 32'h0);
    chk("io_0x08_zero", bus.mem_in, 32'h0);
    cyc();
    idle(2);

    // Same-cycle read+write to a RAM word
    apply(1'b0, 1'b1, 32'h40, 32'h1); cyc();
    idle(2);
    apply(1'b1, 1'b1, 32'h40, 32'h2);
    chk("rw_same_old", bus.mem_in, 32'h1);
    cyc();
    apply(1'b1, 1'b0, 32'h40, 32'h0);
    chk("rw_same_new", bus.mem_in, 32'h2);
    cyc();
    idle(2);

    // Reset discards posted writes but leaves RAM intact
    apply(1'b0, 1'b1, 32'h50, 32'h5); cyc();
    idle(2);
    apply(1'b1, 1'b1, 32'h50, 32'h55); cyc();
    apply(1'b1, 1'b1, 32'h54, 32'h66); cyc();
    apply(1'b1, 1'b1, 32'h58, 32'h77); cyc();
    chk("pre_rst_count", 32'(bus.wb_count), 32'd3);
    rst = 1'b1;
    apply(1'b0, 1'b1, 32'hFF00, 32'h1111_1111);
    cyc();
    rst = 1'b0;
    chk("post_rst_count", 32'(bus.wb_count), 32'd0);
    chk("post_rst_empty", 32'(bus.wb_empty), 32'd1);
    chk("post_rst_out_port", bus.out_port, 32'h0);
    apply(1'b1, 1'b0, 32'hFF04, 32'h0);
    chk("post_rst_counter", bus.mem_in, 32'h0);
    cyc();
    apply(1'b1, 1'b0, 32'h50, 32'h0);
    chk("post_rst_ram_0x50", bus.mem_in, 32'h5);
    cyc();
    apply(1'b1, 1'b0, 32'h40, 32'h0);
    chk("post_rst_ram_0x40", bus.mem_in, 32'h2);
    cyc();

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
